// File: rtl/echo_portal_pkg.sv
// Shared constants and types for the Echo portal request path.
package echo_portal_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned METHOD_SAY     = 0;
    localparam int unsigned HDR_METHOD_MSB = 31;
    localparam int unsigned HDR_METHOD_LSB = 16;
    localparam int unsigned HDR_LEN_MSB    = 15;
    localparam int unsigned HDR_LEN_LSB    = 0;
    localparam int unsigned SAY_LEN        = 1;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } req_state_e;

endpackage

// File: rtl/echo_req_fifo.sv
// Say-argument FIFO: registered full/empty, extra pointer bit disambiguates wrap.
module echo_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic          do_enq;
    logic          do_deq;

    assign do_enq = enq & ~full;
    assign do_deq = deq & ~empty;
    assign head   = mem[rd_ptr[AW-1:0]];

    // Next pointer values; full/empty are derived from these so they register cleanly.
    always_comb begin
        wr_ptr_n = wr_ptr + PW'(do_enq);
        rd_ptr_n = rd_ptr + PW'(do_deq);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            empty  <= (wr_ptr_n == rd_ptr_n);
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr[AW-1:0]] <= enq_data;
        end
    end

endmodule

// File: rtl/echo_request_input.sv
// Echo portal request demarshaller: parses header/payload words, buffers say args,
// and issues say calls to the core under its ready.
module echo_request_input #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned METHOD_SAY = echo_portal_pkg::METHOD_SAY,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic [echo_portal_pkg::DATA_W-1:0]  pipe_enq_v,
    input  logic                                EN_pipe_enq,
    output logic                                RDY_pipe_enq,
    output logic [echo_portal_pkg::DATA_W-1:0]  request_say_v,
    output logic                                EN_request_say,
    input  logic                                RDY_request_say,
    output logic [CNT_W-1:0]                    msg_count,
    output logic [CNT_W-1:0]                    err_count,
    output logic                                err_pulse
);

    import echo_portal_pkg::*;

    req_state_e       state_q;
    req_state_e       state_n;
    logic [LEN_W-1:0] drop_cnt_q;
    logic [LEN_W-1:0] drop_cnt_n;
    logic [LEN_W-1:0] hdr_method;
    logic [LEN_W-1:0] hdr_len;
    logic             hdr_ok;
    logic             accept;
    logic             fifo_enq;
    logic             err_set;
    logic             fifo_full;
    logic             fifo_empty;

    assign hdr_method     = pipe_enq_v[HDR_METHOD_MSB:HDR_METHOD_LSB];
    assign hdr_len        = pipe_enq_v[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_ok         = (hdr_method == LEN_W'(METHOD_SAY)) && (hdr_len == LEN_W'(SAY_LEN));
    assign RDY_pipe_enq   = RST_N & ((state_q != ST_PAY) | ~fifo_full);
    assign accept         = EN_pipe_enq & RDY_pipe_enq;
    assign EN_request_say = RST_N & ~fifo_empty & RDY_request_say;

    echo_req_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .enq      (fifo_enq),
        .enq_data (pipe_enq_v),
        .deq      (EN_request_say),
        .head     (request_say_v),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Message parser: next state, drop counter, FIFO push and error flag.
    always_comb begin
        state_n    = state_q;
        drop_cnt_n = drop_cnt_q;
        fifo_enq   = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_n = ST_PAY;
                    end else begin
                        err_set = 1'b1;
                        if (hdr_len != '0) begin
                            state_n    = ST_DROP;
                            drop_cnt_n = hdr_len - LEN_W'(1);
                        end
                    end
                end
            end
            ST_PAY: begin
                if (accept) begin
                    fifo_enq = 1'b1;
                    state_n  = ST_HDR;
                end
            end
            ST_DROP: begin
                if (accept) begin
                    if (drop_cnt_q == '0) begin
                        state_n = ST_HDR;
                    end else begin
                        drop_cnt_n = drop_cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_n = ST_HDR;
        endcase
    end

    // Parser state, error pulse and saturating statistics.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_HDR;
            drop_cnt_q <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            msg_count  <= '0;
        end else begin
            state_q    <= state_n;
            drop_cnt_q <= drop_cnt_n;
            err_pulse  <= err_set;
            if (err_set && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (EN_request_say && (msg_count != '1)) begin
                msg_count <= msg_count + CNT_W'(1);
            end
        end
    end

    a_enq_when_ready: assert property (@(posedge CLK) disable iff (!RST_N)
        EN_pipe_enq |-> RDY_pipe_enq);

endmodule

// File: tb/tb_echo_request_input.sv
// Directed bench for the Echo request demarshaller.
module tb_echo_request_input;

    localparam int unsigned CW = 4;

    logic          CLK;
    logic          RST_N;
    logic [31:0]   pipe_enq_v;
    logic          EN_pipe_enq;
    logic          RDY_pipe_enq;
    logic [31:0]   request_say_v;
    logic          EN_request_say;
    logic          RDY_request_say;
    logic [CW-1:0] msg_count;
    logic [CW-1:0] err_count;
    logic          err_pulse;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] say_q[$];

    echo_request_input #(
        .DEPTH      (2),
        .METHOD_SAY (0),
        .CNT_W      (CW)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .pipe_enq_v      (pipe_enq_v),
        .EN_pipe_enq     (EN_pipe_enq),
        .RDY_pipe_enq    (RDY_pipe_enq),
        .request_say_v   (request_say_v),
        .EN_request_say  (EN_request_say),
        .RDY_request_say (RDY_request_say),
        .msg_count       (msg_count),
        .err_count       (err_count),
        .err_pulse       (err_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every say that will fire at the coming rising edge.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && EN_request_say === 1'b1) say_q.push_back(request_say_v);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        EN_pipe_enq = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 50 && RDY_pipe_enq !== 1'b1; i++) tick();
        n_vec++;
        if (RDY_pipe_enq !== 1'b1) begin
            n_miss++;
            $display("FAIL send_timeout word=%h rdy=%b required 1", w, RDY_pipe_enq);
        end else begin
            pipe_enq_v  = w;
            EN_pipe_enq = 1'b1;
            tick();
            EN_pipe_enq = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        n_vec++;
        if (RDY_pipe_enq !== 1'b0 || EN_request_say !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ready rdy=%b en=%b required 0 0", RDY_pipe_enq, EN_request_say);
        end
        tick();
        RST_N = 1'b1;
        #1;
        n_vec++;
        if (RDY_pipe_enq !== 1'b1 || EN_request_say !== 1'b0 || msg_count !== 4'd0 ||
            err_count !== 4'd0 || err_pulse !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state rdy=%b en=%b msg=%0d err=%0d pulse=%b required 1 0 0 0 0",
                     RDY_pipe_enq, EN_request_say, msg_count, err_count, err_pulse);
        end
    endtask

    task automatic test_single_say();
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b1;
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        n_vec++;
        if (EN_request_say !== 1'b1 || request_say_v !== 32'hDEAD_BEEF || msg_count !== 4'd0) begin
            n_miss++;
            $display("FAIL single_latency en=%b v=%h msg=%0d required 1 deadbeef 0",
                     EN_request_say, request_say_v, msg_count);
        end
        tick();
        n_vec++;
        if (msg_count !== 4'd1 || EN_request_say !== 1'b0 || say_q.size() != 1 ||
            say_q[0] !== 32'hDEAD_BEEF) begin
            n_miss++;
            $display("FAIL single_done msg=%0d en=%b says=%0d required 1 0 1", msg_count,
                     EN_request_say, say_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3];
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b0;
        send_word(32'h0000_0001);
        send_word(32'd1);
        send_word(32'h0000_0001);
        send_word(32'd2);
        send_word(32'h0000_0001);
        n_vec++;
        if (RDY_pipe_enq !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_ready_low rdy=%b required 0", RDY_pipe_enq);
        end
        RDY_request_say = 1'b1;
        send_word(32'd3);
        wait_cycles(6);
        exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'd3;
        n_vec++;
        if (say_q.size() != 3 || say_q[0] !== exp[0] || say_q[1] !== exp[1] ||
            say_q[2] !== exp[2] || msg_count !== 4'd3) begin
            n_miss++;
            $display("FAIL bp_order says=%0d msg=%0d required 3 3 (args 1,2,3)",
                     say_q.size(), msg_count);
        end
    endtask

    task automatic test_bad_method();
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b1;
        send_word(32'h0005_0003);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 4'd1) begin
            n_miss++;
            $display("FAIL badm_pulse pulse=%b err=%0d required 1 1", err_pulse, err_count);
        end
        send_word(32'h0000_0001);
        n_vec++;
        if (err_pulse !== 1'b0) begin
            n_miss++;
            $display("FAIL badm_pulse_once pulse=%b required 0", err_pulse);
        end
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        send_word(32'h0000_0001);
        send_word(32'd7);
        wait_cycles(3);
        n_vec++;
        if (say_q.size() != 1 || say_q[0] !== 32'd7 || err_count !== 4'd1 || msg_count !== 4'd1) begin
            n_miss++;
            $display("FAIL badm_result says=%0d err=%0d msg=%0d required 1 1 1 (arg 7)",
                     say_q.size(), err_count, msg_count);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b1;
        send_word(32'h0000_0000);
        n_vec++;
        if (err_pulse !== 1'b1) begin
            n_miss++;
            $display("FAIL zlen_pulse pulse=%b required 1", err_pulse);
        end
        send_word(32'h0000_0001);
        send_word(32'd9);
        wait_cycles(3);
        n_vec++;
        if (say_q.size() != 1 || say_q[0] !== 32'd9 || err_count !== 4'd1 || msg_count !== 4'd1) begin
            n_miss++;
            $display("FAIL zlen_result says=%0d err=%0d msg=%0d required 1 1 1 (arg 9)",
                     say_q.size(), err_count, msg_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b0;
        send_word(32'h0000_0001);
        send_word(32'h0000_0011);
        send_word(32'h0000_0001);
        do_reset();
        RDY_request_say = 1'b1;
        wait_cycles(4);
        n_vec++;
        if (say_q.size() != 0 || msg_count !== 4'd0 || err_count !== 4'd0) begin
            n_miss++;
            $display("FAIL mreset_discard says=%0d msg=%0d err=%0d required 0 0 0",
                     say_q.size(), msg_count, err_count);
        end
        send_word(32'h0000_0001);
        send_word(32'h0000_0055);
        wait_cycles(3);
        n_vec++;
        if (say_q.size() != 1 || say_q[0] !== 32'h55 || msg_count !== 4'd1) begin
            n_miss++;
            $display("FAIL mreset_resume says=%0d msg=%0d required 1 1 (arg 55)",
                     say_q.size(), msg_count);
        end
    endtask

    task automatic test_full_deq_and_saturate();
        do_reset();
        say_q.delete();
        RDY_request_say = 1'b0;
        send_word(32'h0000_0001);
        send_word(32'h0000_00A1);
        send_word(32'h0000_0001);
        send_word(32'h0000_00B2);
        send_word(32'h0000_0001);
        RDY_request_say = 1'b1;
        #1;
        n_vec++;
        if (EN_request_say !== 1'b1 || RDY_pipe_enq !== 1'b0) begin
            n_miss++;
            $display("FAIL full_deq_cycle en=%b rdy=%b required 1 0", EN_request_say, RDY_pipe_enq);
        end
        tick();
        n_vec++;
        if (RDY_pipe_enq !== 1'b1) begin
            n_miss++;
            $display("FAIL full_rdy_next rdy=%b required 1", RDY_pipe_enq);
        end
        send_word(32'h0000_00C3);
        wait_cycles(4);
        n_vec++;
        if (say_q.size() != 3 || say_q[0] !== 32'hA1 || say_q[1] !== 32'hB2 ||
            say_q[2] !== 32'hC3 || msg_count !== 4'd3) begin
            n_miss++;
            $display("FAIL full_order says=%0d msg=%0d required 3 3 (a1,b2,c3)",
                     say_q.size(), msg_count);
        end
        for (int i = 0; i < 14; i++) begin
            send_word(32'h0000_0001);
            send_word(32'h100 + 32'(i));
        end
        wait_cycles(4);
        n_vec++;
        if (msg_count !== 4'hF || say_q.size() != 17) begin
            n_miss++;
            $display("FAIL msg_saturate msg=%0d says=%0d required 15 17", msg_count, say_q.size());
        end
        for (int i = 0; i < 16; i++) send_word(32'h0000_0000);
        tick();
        n_vec++;
        if (err_count !== 4'hF) begin
            n_miss++;
            $display("FAIL err_saturate err=%0d required 15", err_count);
        end
    endtask

    initial begin
        RST_N           = 1'b0;
        EN_pipe_enq     = 1'b0;
        pipe_enq_v      = '0;
        RDY_request_say = 1'b0;
        test_reset();
        test_single_say();
        test_backpressure();
        test_bad_method();
        test_zero_len();
        test_mid_reset();
        test_full_deq_and_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
